mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port 256x8 RAM (active-low R/W) between two requesters: port 0 = dCPU-side
//  bus master, port 1 = loader/debug DMA. Per-port req/gnt handshake, round-robin fairness,
//  optional bus lock for multi-access sequences (push/pop, block copy) with a bounded hold.
//  Sits between the requesters and the RAM model; drives the RAM's R, W, addr, data_out directly.
// PARAMETERS
//  AW        8   address width
//  DW        8   data width
//  MAX_HOLD  4   max consecutive locked grants to one port before forced hand-over (>=1)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  req        in   2       per-port access request, held until gnt
//  we         in   2       per-port 1=write 0=read, stable while req
//  lock       in   2       per-port: keep bus after this access if req stays high
//  req_addr   in   2*AW    {addr1,addr0}, stable while req
//  req_wdata  in   2*DW    {wdata1,wdata0}, stable while req
//  gnt        out  2       one-hot pulse: the access for that port happens this cycle
//  rdata      out  DW      registered read data (shared)
//  rvalid     out  2       one-hot pulse, cycle after a read gnt; rdata valid
//  R          out  1       RAM read strobe, active low
//  W          out  1       RAM write strobe, active low
//  addr       out  AW      RAM address (registered)
//  data_out   out  DW      RAM write data (registered)
//  mem_in     in   DW      RAM read data, combinational from addr while R low
// BEHAVIOUR
//  Reset (sync): state=IDLE, gnt=0, rvalid=0, rdata=0, addr=0, data_out=0, R=W=1, owner=1
//   (so port 0 wins first tie), hold_cnt=0. Reset mid-ACCESS aborts it: no gnt/rvalid afterward.
//  States: IDLE, ACCESS, TURN.
//   IDLE: pick = rr(req, owner); if any req -> latch addr/wdata/we of pick, owner<=pick, ACCESS.
//   ACCESS: gnt[owner]=1; R=0 if read else W=0 (never both low). Write lands in RAM on the
//    posedge ending ACCESS; read mem_in captured into rdata on that edge, rvalid[owner] next cycle.
//    Next (req[owner] re-sampled only from the cycle after gnt, i.e. not this cycle's req):
//    - lock[owner] & hold_cnt<MAX_HOLD-1: wait in ACCESS? no -> go IDLE-equivalent but pick=owner
//      only; if owner re-requests next cycle -> ACCESS, hold_cnt++.
//    - else other port requesting -> TURN; none -> IDLE; hold_cnt<=0 on owner change.
//   TURN: one dead cycle, R=W=1 (bus turnaround on owner change); then ACCESS with new owner.
//  Latency: req seen at edge N -> gnt in cycle N+1 (from IDLE); read data rvalid at N+2.
//   Same-owner back-to-back: one access per 2 cycles (IDLE/ACCESS alternation);
//   owner change costs +1 (TURN).
//  Round robin: both req -> grant port != owner. Single req -> that port.
//  Lock: while owner holds lock and hold_cnt<MAX_HOLD, the other port is refused even if
//   requesting; at MAX_HOLD consecutive locked grants, the other port, if requesting, is
//   served next; hold_cnt cleared.
//  Requester rules: req must be held until gnt; dropping req before gnt is legal (no access).
//   we/addr/wdata changes while req high -> undefined (bench flags).
//  Invariants: $onehot0(gnt); $onehot0(rvalid); !(R==0 && W==0); gnt => state==ACCESS.
// STRUCTURE
//  Shared defines header: ARB_IDLE/ARB_ACCESS/ARB_TURN (2-bit) and RW_ACTIVE=1'b0 strobe level,
//   alongside existing BUS_MUX_/ADDR_MUX_ defines.
//  Sub-module rr_pick2: combinational 2-way round-robin chooser (req, owner, lock_mask) -> pick,
//   any. FSM, hold counter, addr/data/rdata registers in the top.
// TESTING
//  1 req0 read addr 0x10 (mem=0xC1) -> gnt0 cycle N+1, R=0 addr=0x10, rvalid0 N+2, rdata=0xC1.
//  2 req0 write 0x20<-0x5A, req1 read 0x20 same cycle -> port0 first (reset owner=1), TURN,
//    then port1 reads 0x5A; W,R never low together.
//  3 both req continuously, no lock -> grants alternate 0,1,0,1 with a TURN between each.
//  4 port1 lock=1, 6 back-to-back reads, port0 requesting; MAX_HOLD=4 -> 4 port1 grants,
//    then port0 served, then port1 resumes.
//  5 rst pulse during ACCESS of a write -> no gnt/rvalid after reset, R=W=1 next cycle,
//    port0 wins next tie.
//  6 req0 dropped before gnt while in TURN -> no access for port0; state falls to IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings and strobe levels for the RAM bus arbiter
//
// Contents:
//   arb_state_e  : ARB_IDLE / ARB_ACCESS / ARB_TURN (2-bit)
//   RW_ACTIVE    : asserted level of the RAM R/W strobes (active low)
//   RW_IDLE      : released level of the RAM R/W strobes
//   port_onehot  : 1-bit port index -> 2-bit one-hot vector

package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_TURN   = 2'd2
    } arb_state_e;

    localparam logic RW_ACTIVE = 1'b0;
    localparam logic RW_IDLE   = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and RAM-side signal bundle of the two-port RAM arbiter
//
// Requester side (per port, packed {port1,port0}):
//   req, we, lock, req_addr, req_wdata : requester -> arbiter
//   gnt, rvalid                        : arbiter -> requester (one-hot pulses)
//   rdata                              : arbiter -> requester (shared, registered)
// RAM side:
//   R, W      : active-low read / write strobes
//   addr      : RAM address (registered)
//   data_out  : RAM write data (registered)
//   mem_in    : RAM read data, combinational from addr while R is low
// Modports: slave = arbiter, master = requesters plus RAM model.

interface mem_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [1:0]      req;
    logic [1:0]      we;
    logic [1:0]      lock;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      gnt;
    logic [DW-1:0]   rdata;
    logic [1:0]      rvalid;
    logic            R;
    logic            W;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data_out;
    logic [DW-1:0]   mem_in;

    modport slave (
        input  req, we, lock, req_addr, req_wdata, mem_in,
        output gnt, rdata, rvalid, R, W, addr, data_out
    );

    modport master (
        output req, we, lock, req_addr, req_wdata, mem_in,
        input  gnt, rdata, rvalid, R, W, addr, data_out
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - combinational two-way round-robin chooser
//
// Ports:
//   req       in  2  per-port request
//   owner     in  1  port that was granted most recently
//   lock_mask in  1  owner holds a lock: if the owner is requesting, only it is eligible
//   pick      out 1  chosen port (meaningful when pick_any)
//   pick_any  out 1  at least one eligible request

module rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       lock_mask,
    output logic       pick,
    output logic       pick_any
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req;
        // A lock only pins the bus while the owner keeps asking; otherwise it lapses.
        if (lock_mask && req[owner]) begin
            eligible = port_onehot(owner);
        end
        pick_any = |eligible;
        case (eligible)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~owner;
            default: pick = owner;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one 256x8 RAM between CPU port 0 and DMA port 1
//
// Parameters: AW address width, DW data width, MAX_HOLD max consecutive locked grants (>=1).
// Ports:
//   clk  in  clock, all state updates on posedge
//   rst  in  synchronous active-high reset
//   bus  slave modport of mem_bus_arbiter_if (requester handshake + RAM strobes/address/data)
// Every access takes one ACCESS cycle; same-owner accesses alternate IDLE/ACCESS and an owner
// change out of ACCESS inserts one TURN dead cycle with both strobes released.

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int             HCW       = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    arb_state_e     state;
    logic           owner;
    logic           locked;      // one-cycle flag: IDLE following a locked grant
    logic           cur_we;
    logic [HCW-1:0] hold_cnt;    // locked grants to owner beyond the first in this run

    logic           pick;
    logic           pick_any;
    logic           sel;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

    rr_pick2 u_rr_pick2 (
        .req      (bus.req),
        .owner    (owner),
        .lock_mask(locked),
        .pick     (pick),
        .pick_any (pick_any)
    );

    // Port whose request would be launched this cycle: fresh arbitration in IDLE,
    // the already-chosen owner when coming out of TURN.
    always_comb begin
        sel       = (state == ARB_IDLE) ? pick : owner;
        sel_we    = bus.we[sel];
        sel_addr  = sel ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
        sel_wdata = sel ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            owner        <= 1'b1;
            locked       <= 1'b0;
            cur_we       <= 1'b0;
            hold_cnt     <= '0;
            bus.gnt      <= 2'b00;
            bus.rvalid   <= 2'b00;
            bus.rdata    <= '0;
            bus.addr     <= '0;
            bus.data_out <= '0;
            bus.R        <= RW_IDLE;
            bus.W        <= RW_IDLE;
        end else begin
            bus.gnt    <= 2'b00;
            bus.rvalid <= 2'b00;
            bus.R      <= RW_IDLE;
            bus.W      <= RW_IDLE;
            locked     <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        owner        <= pick;
                        cur_we       <= sel_we;
                        bus.addr     <= sel_addr;
                        bus.data_out <= sel_wdata;
                        bus.gnt      <= port_onehot(pick);
                        if (sel_we) bus.W <= RW_ACTIVE;
                        else        bus.R <= RW_ACTIVE;
                        state        <= ARB_ACCESS;
                        // pick == owner under a live lock means the owner is continuing its run
                        if (locked && pick == owner) hold_cnt <= hold_cnt + 1'b1;
                        else                         hold_cnt <= '0;
                    end else begin
                        hold_cnt <= '0;
                    end
                end

                ARB_ACCESS: begin
                    if (!cur_we) begin
                        bus.rdata  <= bus.mem_in;
                        bus.rvalid <= port_onehot(owner);
                    end
                    // req[owner] is deliberately not looked at here: it still belongs to
                    // the access being granted right now.
                    if (bus.lock[owner] && hold_cnt < HOLD_LAST) begin
                        locked <= 1'b1;
                        state  <= ARB_IDLE;
                    end else begin
                        hold_cnt <= '0;
                        if (bus.req[~owner]) begin
                            owner <= ~owner;
                            state <= ARB_TURN;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end
                end

                ARB_TURN: begin
                    // The new owner may have withdrawn during the dead cycle.
                    if (bus.req[owner]) begin
                        cur_we       <= sel_we;
                        bus.addr     <= sel_addr;
                        bus.data_out <= sel_wdata;
                        bus.gnt      <= port_onehot(owner);
                        if (sel_we) bus.W <= RW_ACTIVE;
                        else        bus.R <= RW_ACTIVE;
                        state        <= ARB_ACCESS;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
